// File: rtl/elevator_call_panel.sv
// elevator_call_panel: debounced call/hold front end that issues one call at a time to the 3-floor controller.
// Define ELEVATOR_CALL_TIMEOUT_EN to add the WAIT_ARRIVE watchdog and the sticky timeout_err flag.
module elevator_call_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DWELL_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] call_raw,
  input  logic       hold_raw,
  input  logic [2:0] floor_ind,
  output logic [2:0] btn_req,
  output logic       hold_req,
  output logic [2:0] pending,
  output logic       busy,
  output logic [1:0] served_floor,
  output logic       timeout_err
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WW = $clog2(DWELL_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ARRIVE, DWELL, RELEASE} state_t;
  if (DEBOUNCE_CYCLES < 1 || DWELL_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("elevator_call_panel: cycle parameters must be >= 1");
  end
  state_t state_q, state_d;
  logic [3:0] s1_q, s2_q, db_q, db_d;
  logic [3:0][DW-1:0] cnt_q, cnt_d;
  logic [2:0] pend_q, pend_d, btn_q, btn_d, rise, ign, clr, tgt_oh;
  logic [1:0] tgt_q, tgt_d, last_q, last_d, served_q, served_d, c1, c2, c3, pick;
  logic [WW-1:0] dwell_q, dwell_d;
  logic hold_q, hold_d;
`ifdef ELEVATOR_CALL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_q, wd_d;
  logic err_q, err_d;
`endif
  function automatic logic [1:0] nxt(input logic [1:0] f);
    return (f == 2'd3 || f == 2'd0) ? 2'd1 : f + 2'd1;
  endfunction
  function automatic logic [2:0] oh(input logic [1:0] f);
    return {f == 2'd3, f == 2'd2, f == 2'd1};
  endfunction
  // bit 3 is the door-hold button, bits 2:0 the floor calls
  always_comb
    for (int i = 0; i < 4; i++) begin
      db_d[i] = (s2_q[i] != db_q[i] && cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) ? ~db_q[i] : db_q[i];
      cnt_d[i] = (s2_q[i] == db_q[i] || db_d[i] != db_q[i]) ? '0 : cnt_q[i] + DW'(1);
    end
  always_comb begin
    state_d = state_q;
    tgt_d = tgt_q;
    last_d = last_q;
    served_d = served_q;
    dwell_d = dwell_q;
    clr = 3'b000;
`ifdef ELEVATOR_CALL_TIMEOUT_EN
    wd_d = wd_q;
    err_d = err_q;
`endif
    c1 = nxt(last_q);
    c2 = nxt(c1);
    c3 = nxt(c2);
    pick = pend_q[c1 - 2'd1] ? c1 : pend_q[c2 - 2'd1] ? c2 : c3;
    tgt_oh = oh(tgt_q);
    case (state_q)
      IDLE: if (|pend_q) begin
        tgt_d = pick;
        state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT_ARRIVE;
`ifdef ELEVATOR_CALL_TIMEOUT_EN
        wd_d = '0;
`endif
      end
      WAIT_ARRIVE: if (floor_ind == tgt_oh) begin
        dwell_d = WW'(DWELL_CYCLES);
        state_d = DWELL;
`ifdef ELEVATOR_CALL_TIMEOUT_EN
        err_d = 1'b0;
      end else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
        err_d = 1'b1;
        state_d = RELEASE;
      end else begin
        wd_d = wd_q + TW'(1);
`endif
      end
      // a held door keeps reloading the dwell so the car never leaves while it is pressed
      DWELL: begin
        dwell_d = db_q[3] ? WW'(DWELL_CYCLES) : dwell_q - WW'(1);
        if (!db_q[3] && dwell_q == WW'(1)) state_d = RELEASE;
      end
      RELEASE: begin
        clr = tgt_oh;
        last_d = tgt_q;
`ifdef ELEVATOR_CALL_TIMEOUT_EN
        served_d = err_q ? served_q : tgt_q;
`else
        served_d = tgt_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ign = state_q == IDLE ? 3'b000 : tgt_oh;
    rise = db_d[2:0] & ~db_q[2:0];
    pend_d = (pend_q | (rise & ~ign)) & ~clr;
    btn_d = state_d == ISSUE ? oh(tgt_d) : 3'b000;
    hold_d = state_d == RELEASE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      cnt_q <= '0;
      pend_q <= '0;
      btn_q <= '0;
      hold_q <= 1'b0;
      tgt_q <= '0;
      last_q <= '0;
      served_q <= '0;
      dwell_q <= '0;
`ifdef ELEVATOR_CALL_TIMEOUT_EN
      wd_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s1_q <= {hold_raw, call_raw};
      s2_q <= s1_q;
      db_q <= db_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      btn_q <= btn_d;
      hold_q <= hold_d;
      tgt_q <= tgt_d;
      last_q <= last_d;
      served_q <= served_d;
      dwell_q <= dwell_d;
`ifdef ELEVATOR_CALL_TIMEOUT_EN
      wd_q <= wd_d;
      err_q <= err_d;
`endif
    end
  assign btn_req = btn_q;
  assign hold_req = hold_q;
  assign pending = pend_q;
  assign busy = state_q != IDLE;
  assign served_floor = served_q;
`ifdef ELEVATOR_CALL_TIMEOUT_EN
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_elevator_call_panel.sv
// tb_elevator_call_panel: scoreboard bench; expected btn_req/hold_req pulses (with cycle stamp) are queued by the stimulus
// and popped by a negedge monitor whenever the panel emits a pulse.
module tb_elevator_call_panel;
  logic clk = 1'b0, reset;
  logic [2:0] call_raw, floor_ind, btn_req, pending;
  logic hold_raw, hold_req, busy, timeout_err;
  logic [1:0] served_floor;
  int cyc = 0, n_cmp = 0, n_bad = 0, t, b, c;
  typedef struct {
    int cyc;
    logic [2:0] btn;
    logic hold;
    logic [2:0] pend;
    logic [1:0] srv;
  } ev_t;
  ev_t exp_q[$];
  ev_t e;

  elevator_call_panel dut (
    .clk(clk), .reset(reset), .call_raw(call_raw), .hold_raw(hold_raw), .floor_ind(floor_ind),
    .btn_req(btn_req), .hold_req(hold_req), .pending(pending), .busy(busy),
    .served_floor(served_floor), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int ec, input logic [2:0] eb, input logic eh, input logic [2:0] ep, input logic [1:0] es);
    ev_t x;
    x.cyc = ec; x.btn = eb; x.hold = eh; x.pend = ep; x.srv = es;
    exp_q.push_back(x);
  endtask

  // Called on the cycle the ISSUE pulse is visible; arrival is driven three cycles later.
  task automatic serve(input logic [2:0] fl, input int bc, input logic [2:0] p, input logic [1:0] s);
    step(3);
    floor_ind = fl;
    expect_ev(bc + 12, 3'b000, 1'b1, p, s);
    step(10);
    floor_ind = 3'b000;
  endtask

  always @(negedge clk)
    if (btn_req != 3'b000 || hold_req) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", {btn_req, hold_req}, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("pulse{cyc,btn,hold,pend,srv}", {32'(cyc), btn_req, hold_req, pending, served_floor},
            {32'(e.cyc), e.btn, e.hold, e.pend, e.srv});
      end
    end

  initial begin
    reset = 1'b1; call_raw = '0; hold_raw = 1'b0; floor_ind = '0;
    step(3);
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_served", served_floor, 0);
    chk("rst_pulses", {btn_req, hold_req}, 0);
    chk("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    step(2);
    // 3-cycle glitch on floor 2 must be rejected
    call_raw = 3'b010; step(3); call_raw = 3'b000; step(8);
    chk("glitch_pending", pending, 0);
    // held call: pending on the 6th edge counting the first sampling edge
    t = cyc; call_raw = 3'b010;
    expect_ev(t + 7, 3'b010, 1'b0, 3'b010, 2'd0);
    step(5);
    chk("debounce_early", pending, 3'b000);
    step(1);
    chk("debounce_latency", pending, 3'b010);
    chk("idle_busy", busy, 0);
    call_raw = 3'b000; step(1);
    chk("issue_busy", busy, 1);
    serve(3'b010, t + 7, 3'b010, 2'd0);
    chk("f2_served", served_floor, 2);
    chk("f2_pending", pending, 0);
    chk("f2_busy", busy, 0);
    // single service of floor 3
    t = cyc; call_raw = 3'b100;
    expect_ev(t + 7, 3'b100, 1'b0, 3'b100, 2'd2);
    step(6); call_raw = 3'b000; step(1);
    serve(3'b100, t + 7, 3'b100, 2'd2);
    chk("f3_served", served_floor, 3);
    chk("f3_pending", pending, 0);
    chk("f3_busy", busy, 0);
    // round robin after reset: floor 1 first, floor 3 issued two cycles after its release
    reset = 1'b1; step(2); reset = 1'b0; step(2);
    chk("rr_served_cleared", served_floor, 0);
    t = cyc; call_raw = 3'b101;
    expect_ev(t + 7, 3'b001, 1'b0, 3'b101, 2'd0);
    step(6); call_raw = 3'b000; step(1);
    b = cyc;
    step(3); floor_ind = 3'b001;
    expect_ev(b + 12, 3'b000, 1'b1, 3'b101, 2'd0);
    c = b + 14;
    expect_ev(c, 3'b100, 1'b0, 3'b100, 2'd1);
    step(11); floor_ind = 3'b000;
    // door hold during floor-3 dwell, plus a re-press of the target call
    step(3); floor_ind = 3'b100;
    step(1); hold_raw = 1'b1;
    step(8); call_raw = 3'b100;
    chk("dwell_busy", busy, 1);
    step(8); call_raw = 3'b000;
    step(4); hold_raw = 1'b0;
    expect_ev(c + 38, 3'b000, 1'b1, 3'b100, 2'd1);
    step(6);
    chk("hold_extends_busy", busy, 1);
    step(9);
    chk("repress_pending", pending, 0);
    chk("hold_served", served_floor, 3);
    chk("hold_busy", busy, 0);
    floor_ind = 3'b000;
    // asynchronous reset while waiting for arrival
    t = cyc; call_raw = 3'b010;
    expect_ev(t + 7, 3'b010, 1'b0, 3'b010, 2'd3);
    step(6); call_raw = 3'b000; step(4);
    chk("wait_busy", busy, 1);
    #2 reset = 1'b1; #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_pending", pending, 0);
    chk("async_rst_served", served_floor, 0);
    chk("async_rst_pulses", {btn_req, hold_req}, 0);
    step(2); reset = 1'b0; step(20);
    chk("post_rst_busy", busy, 0);
    // no arrival on floor 1
    t = cyc; call_raw = 3'b001;
    expect_ev(t + 7, 3'b001, 1'b0, 3'b001, 2'd0);
    step(6); call_raw = 3'b000; step(2);
    chk("wait_timeout_err", timeout_err, 0);
`ifdef ELEVATOR_CALL_TIMEOUT_EN
    expect_ev(t + 40, 3'b000, 1'b1, 3'b001, 2'd0);
    step(33);
    chk("to_err_set", timeout_err, 1);
    chk("to_served_kept", served_floor, 0);
    chk("to_pending", pending, 0);
    chk("to_busy", busy, 0);
`else
    step(40);
    chk("no_to_busy", busy, 1);
    chk("no_to_err", timeout_err, 0);
`endif
    step(3);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/elevator_call_panel.md
Name: elevator_call_panel

Overview:
- Passenger-side front end for the 3-floor elevator controller; the request initiator feeding the controller's button_1..3/hold inputs.
- Synchronises and debounces raw call buttons and a door-hold button, latches pending calls as lamps, and issues one call at a time to the controller.
- Watches the controller's floor_1..3 indicators for arrival, dwells at the floor, then pulses hold to return the controller to IDLE and clears the call.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a synchronised input changes its debounced level (>=1).
- DWELL_CYCLES, 8, cycles the car dwells at a served floor before release (>=1).
- TIMEOUT_CYCLES, 32, WAIT_ARRIVE watchdog limit; used only with ELEVATOR_CALL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears every register
- call_raw  in  3  raw call buttons; bit0=floor1, bit1=floor2, bit2=floor3; asynchronous and bouncy
- hold_raw  in  1  raw door-hold button; bouncy
- floor_ind  in  3  controller floor_1..3 indicators; bit0=floor1
- btn_req  out  3  one-hot, single-cycle call pulse to controller button_1..3
- hold_req  out  1  single-cycle pulse to controller hold
- pending  out  3  latched call lamps
- busy  out  1  high whenever FSM is not IDLE
- served_floor  out  2  last floor served, 1..3; 0 = none since reset
- timeout_err  out  1  sticky watchdog flag; constant 0 when the feature is off

Behaviour:
- Reset (async, any state): all outputs 0; FSM=IDLE; pending, target, last_served, counters, sync flops and debounced levels all 0.
- Input path, per bit (4 bits: call_raw[2:0], hold_raw): 2-flop synchroniser feeds a debouncer.
  - Counter increments while the sync output != debounced level; it clears when they are equal.
  - Debounced level toggles on the edge where the count would reach DEBOUNCE_CYCLES.
  - Pulses shorter than DEBOUNCE_CYCLES cycles at the sync output are ignored.
- Pending: a debounced call rising edge sets pending[i] on the same edge the debounced level rises.
  - Latency: pending[i] is visible DEBOUNCE_CYCLES+2 cycles after the first clk edge sampling call_raw[i]=1.
  - A call edge for the current target while in ISSUE/WAIT_ARRIVE/DWELL/RELEASE is ignored.
  - A call for any other floor is latched at any time.
- FSM states: IDLE, ISSUE, WAIT_ARRIVE, DWELL, RELEASE.
  - IDLE: if pending!=0, pick target round-robin, searching upward from last_served+1 with wrap 3->1 (last_served=0 behaves as 3, so floor1 wins first); latch target; go to ISSUE next cycle.
  - ISSUE: btn_req=onehot(target) for exactly 1 cycle; go to WAIT_ARRIVE.
  - WAIT_ARRIVE: when floor_ind==onehot(target) exactly, load dwell counter with DWELL_CYCLES and go to DWELL. Any other floor_ind value, including multi-hot, keeps waiting.
  - DWELL: counter decrements each cycle. While debounced hold is 1, the counter reloads to DWELL_CYCLES, so dwell is extended indefinitely. At 0, go to RELEASE.
  - RELEASE: hold_req=1 for 1 cycle; clear pending[target]; last_served<=target; served_floor<=target; go to IDLE.
- btn_req and hold_req are registered, never both high, and 0 in every other state.
- Back-to-back calls: next ISSUE occurs 2 cycles after RELEASE (RELEASE->IDLE->ISSUE).
- Simultaneous pending set on a non-target bit and clear on the target bit in RELEASE: both take effect.

Optional Feature:
- ELEVATOR_CALL_TIMEOUT_EN defined:
  - A watchdog counts cycles in WAIT_ARRIVE.
  - On reaching TIMEOUT_CYCLES without arrival: go to RELEASE, so hold_req pulses, pending[target] clears and last_served updates, but served_floor is not updated; timeout_err sets.
  - timeout_err clears on the next successful arrival (WAIT_ARRIVE->DWELL) or on reset.
- Undefined: WAIT_ARRIVE waits indefinitely; timeout_err is tied to 0; TIMEOUT_CYCLES is unused.

Test Plan (DEBOUNCE_CYCLES=4, DWELL_CYCLES=8, TIMEOUT_CYCLES=32):
- Debounce: call_raw[1] glitches high for 3 cycles -> pending stays 000. Then held high -> pending=010 exactly 6 cycles after the first sampling edge.
- Single service: pending=100 -> btn_req=100 for 1 cycle. Bench drives floor_ind=100 three cycles later -> 8 dwell cycles, then hold_req 1 cycle, pending=000, served_floor=3, busy=0.
- Round-robin: calls on floors 1 and 3 latched together after reset -> floor1 served first, then btn_req=100 two cycles after the floor1 RELEASE.
- Door hold: during DWELL, hold_raw high for 20 cycles -> hold_req delayed until 8 cycles after debounced hold falls. Re-pressing the target call during DWELL leaves its pending bit cleared after RELEASE.
- Reset mid-operation: assert reset in WAIT_ARRIVE -> all outputs 0 immediately (async), FSM=IDLE, and no btn_req after reset deasserts.
- Timeout (macro defined): floor_ind held 000 after ISSUE -> RELEASE after 32 WAIT_ARRIVE cycles, timeout_err=1, served_floor unchanged. Macro undefined: busy stays 1 and timeout_err stays 0.
